cpu_step_sequencer: RTL

Multi-cycle sequencer for the single-issue MIPS-style core. It sits between the combinational opcode decoder and the datapath. It turns the decoder's level control flags into one-cycle-qualified enables: PC update, IR load, register write and memory write. It also stalls the core on input, output and ROM-swap handshakes, and holds the core after HALT.

---
 rtl/cpu_step_sequencer_pkg.sv | 30 +++
 rtl/cpu_step_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cpu_step_sequencer_pkg.sv
// Shared constants for the step sequencer and the opcode decoder.
// Latency: none (constants only).
// Backpressure: none (constants only).
package cpu_step_sequencer_pkg;

    // Sequencer state encodings. Value 7 is unused and recovers to FETCH.
    localparam logic [2:0] SEQ_FETCH    = 3'd0;
    localparam logic [2:0] SEQ_EXEC     = 3'd1;
    localparam logic [2:0] SEQ_MEM_RD   = 3'd2;
    localparam logic [2:0] SEQ_WAIT_IN  = 3'd3;
    localparam logic [2:0] SEQ_WAIT_OUT = 3'd4;
    localparam logic [2:0] SEQ_SWAP_ROM = 3'd5;
    localparam logic [2:0] SEQ_HALTED   = 3'd6;

    // Writeback select value that marks a load from data memory.
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;

    // Opcodes decoded by the control unit.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_IN    = 6'h3c;
    localparam logic [5:0] OP_OUT   = 6'h3d;
    localparam logic [5:0] OP_CHROM = 6'h3e;
    localparam logic [5:0] OP_HALT  = 6'h3f;

endpackage

// File: rtl/cpu_step_sequencer.sv
// Multi-cycle step sequencer: turns level decoder flags into one-cycle enables.
// Latency: normal 2 cycles, load 3, I/O and ROM swap 2 + wait cycles.
// Backpressure: stalls in WAIT_IN/WAIT_OUT/SWAP_ROM until in_valid/out_ready/rom_ready.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   halt .. memtoReg             decoder flags, stable for the whole instruction
//   in_valid/out_ready/rom_ready handshake inputs, only looked at in their wait state
//   resume                       leaves HALTED
//   ir_load .. halted            Mealy enables/status, all forced low while rst is high
//   state, instr_count           debug state and retired-instruction counter
module cpu_step_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             input_flag,
    input  logic             output_flag,
    input  logic             changeROM,
    input  logic             regWrite,
    input  logic             memWrite,
    input  logic [1:0]       memtoReg,
    input  logic             in_valid,
    input  logic             out_ready,
    input  logic             rom_ready,
    input  logic             resume,
    output logic             ir_load,
    output logic             pc_en,
    output logic             reg_we,
    output logic             mem_we,
    output logic             in_ack,
    output logic             out_valid,
    output logic             rom_swap_req,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);
    import cpu_step_sequencer_pkg::*;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;

    // Next state and Mealy enables. Everything is held low while rst is
    // high so an abandoned handshake never sees a stray ack or write.
    always_comb begin
        state_d      = state_q;
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        reg_we       = 1'b0;
        mem_we       = 1'b0;
        in_ack       = 1'b0;
        out_valid    = 1'b0;
        rom_swap_req = 1'b0;
        halted       = 1'b0;
        if (!rst) begin
            case (state_q)
                SEQ_FETCH: begin
                    ir_load = 1'b1;
                    state_d = SEQ_EXEC;
                end
                SEQ_EXEC: begin
                    if (halt)                          state_d = SEQ_HALTED;
                    else if (changeROM)                state_d = SEQ_SWAP_ROM;
                    else if (input_flag)               state_d = SEQ_WAIT_IN;
                    else if (output_flag)              state_d = SEQ_WAIT_OUT;
                    else if (memtoReg == MEMTOREG_MEM) state_d = SEQ_MEM_RD;
                    else begin
                        reg_we  = regWrite;
                        mem_we  = memWrite;
                        pc_en   = 1'b1;
                        state_d = SEQ_FETCH;
                    end
                end
                SEQ_MEM_RD: begin
                    // Synchronous RAM data is valid now; write it back.
                    reg_we  = 1'b1;
                    pc_en   = 1'b1;
                    state_d = SEQ_FETCH;
                end
                SEQ_WAIT_IN: begin
                    if (in_valid) begin
                        reg_we  = 1'b1;
                        in_ack  = 1'b1;
                        pc_en   = 1'b1;
                        state_d = SEQ_FETCH;
                    end
                end
                SEQ_WAIT_OUT: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        pc_en   = 1'b1;
                        state_d = SEQ_FETCH;
                    end
                end
                SEQ_SWAP_ROM: begin
                    rom_swap_req = 1'b1;
                    // PC mux already selects the new-bank target.
                    if (rom_ready) begin
                        pc_en   = 1'b1;
                        state_d = SEQ_FETCH;
                    end
                end
                SEQ_HALTED: begin
                    halted = 1'b1;
                    // pc_en steps past the HALT instruction on resume.
                    if (resume) begin
                        pc_en   = 1'b1;
                        state_d = SEQ_FETCH;
                    end
                end
                default: state_d = SEQ_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pc_en) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign state       = rst ? 3'd0 : state_q;
    assign instr_count = rst ? '0 : cnt_q;

endmodule
